// File: rtl/mux_pkg.sv
// mux_pkg: shared select codes and default width for the 4:1 selector
package mux_pkg;
  localparam logic [1:0] SEL_I0 = 2'b00;
  localparam logic [1:0] SEL_I1 = 2'b01;
  localparam logic [1:0] SEL_I2 = 2'b10;
  localparam logic [1:0] SEL_I3 = 2'b11;
  localparam int MUX_WIDTH_DEF = 3;
endpackage

// File: rtl/mux4_comb.sv
// mux4_comb: purely combinational 4:1 selector
module mux4_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEF
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] y
);
  // fully decoded select; the up-front assignment keeps y latch-free
  always_comb begin
    y = i0;
    case (sel)
      SEL_I0: y = i0;
      SEL_I1: y = i1;
      SEL_I2: y = i2;
      SEL_I3: y = i3;
    endcase
  end
endmodule

// File: rtl/mux_4to1.sv
// mux_4to1: 4:1 selector with combinational output and an enabled register stage
module mux_4to1
  import mux_pkg::*;
#(
  parameter int               WIDTH     = MUX_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [1:0]       sel_q
);
  mux4_comb #(.WIDTH(WIDTH)) u_comb (
    .sel(sel),
    .i0(i0),
    .i1(i1),
    .i2(i2),
    .i3(i3),
    .y(y)
  );
  // capture the selected data and its select code on enabled edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= RESET_VAL;
      sel_q <= SEL_I0;
    end else if (en) begin
      y_q   <= y;
      sel_q <= sel;
    end
  end
endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: directed plus random scoreboard checks of the 4:1 selector
module tb_mux_4to1;
  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [1:0] sel, sel_q;
  logic [2:0] i0, i1, i2, i3, y, y_q;
  logic [2:0] exp_q[$];
  string      tag_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] m_yq, m_y;
  logic [1:0] m_selq;
  mux_4to1 #(.WIDTH(3), .RESET_VAL(3'b000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .sel(sel),
    .i0(i0),
    .i1(i1),
    .i2(i2),
    .i3(i3),
    .y(y),
    .y_q(y_q),
    .sel_q(sel_q)
  );
  always #5 clk = ~clk;
  task automatic expect_v(input string tag, input logic [2:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask
  task automatic check(input logic [2:0] obs);
    logic [2:0] e;
    string      t;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %b, expected nothing queued", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %b expected %b", t, obs, e);
      end
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [2:0] pick(input logic [1:0] s, input logic [2:0] a, b, c, d);
    return s == 2'd0 ? a : s == 2'd1 ? b : s == 2'd2 ? c : d;
  endfunction
  initial begin
    rst_n = 1'b0; en = 1'b0; sel = 2'b00;
    i0 = 3'b000; i1 = 3'b100; i2 = 3'b010; i3 = 3'b001;
    #1;
    expect_v("reset_yq", 3'b000); check(y_q);
    expect_v("reset_selq", 3'b000); check({1'b0, sel_q});
    en = 1'b1; sel = 2'b11;
    tick(); tick();
    expect_v("reset_hold_yq", 3'b000); check(y_q);
    expect_v("reset_hold_selq", 3'b000); check({1'b0, sel_q});
    @(negedge clk); rst_n = 1'b1; en = 1'b0;
    sel = 2'b00; #1; expect_v("comb_sel00", 3'b000); check(y);
    sel = 2'b01; #1; expect_v("comb_sel01", 3'b100); check(y);
    sel = 2'b11; #1; expect_v("comb_sel11", 3'b001); check(y);
    sel = 2'b10; #1; expect_v("comb_sel10", 3'b010); check(y);
    @(negedge clk); en = 1'b1; sel = 2'b01;
    tick();
    expect_v("reg_yq_01", 3'b100); check(y_q);
    expect_v("reg_selq_01", 3'b001); check({1'b0, sel_q});
    @(negedge clk); sel = 2'b11; #1;
    expect_v("reg_yq_wait", 3'b100); check(y_q);
    tick();
    expect_v("reg_yq_11", 3'b001); check(y_q);
    expect_v("reg_selq_11", 3'b011); check({1'b0, sel_q});
    @(negedge clk); en = 1'b0; sel = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_v("hold_yq", 3'b001); check(y_q);
      expect_v("hold_selq", 3'b011); check({1'b0, sel_q});
      expect_v("hold_y", 3'b100); check(y);
    end
    @(negedge clk); rst_n = 1'b0; #1;
    expect_v("async_rst_yq", 3'b000); check(y_q);
    expect_v("async_rst_selq", 3'b000); check({1'b0, sel_q});
    en = 1'b1; sel = 2'b01;
    for (int k = 0; k < 2; k++) begin
      tick();
      expect_v("rst_vs_en_yq", 3'b000); check(y_q);
      expect_v("rst_vs_en_y", 3'b100); check(y);
    end
    @(negedge clk); rst_n = 1'b1; sel = 2'b10;
    tick();
    expect_v("post_rst_yq", 3'b010); check(y_q);
    expect_v("post_rst_selq", 3'b010); check({1'b0, sel_q});
    @(negedge clk); i2 = 3'b111; #1;
    expect_v("follow_y", 3'b111); check(y);
    expect_v("follow_yq_old", 3'b010); check(y_q);
    tick();
    expect_v("follow_yq", 3'b111); check(y_q);
    @(negedge clk); sel = 2'b00; i0 = 3'b101;
    tick();
    expect_v("simul_yq", 3'b101); check(y_q);
    expect_v("simul_selq", 3'b000); check({1'b0, sel_q});
    m_yq = 3'b101; m_selq = 2'b00;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      en = 1'($urandom_range(0, 1)); sel = 2'($urandom_range(0, 3));
      i0 = 3'($urandom); i1 = 3'($urandom); i2 = 3'($urandom); i3 = 3'($urandom);
      #1;
      m_y = pick(sel, i0, i1, i2, i3);
      expect_v("rand_y", m_y); check(y);
      if (en) begin
        m_yq = m_y;
        m_selq = sel;
      end
      tick();
      expect_v("rand_yq", m_yq); check(y_q);
      expect_v("rand_selq", {1'b0, m_selq}); check({1'b0, sel_q});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
